// File: rtl/align_shift_pkg.sv
// Shared types and sizing helpers for the sequential alignment shifter.
// Imported by the shifter top and its per-chunk stage.
package align_shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic int nstages(input int logsz, input int r);
    return (logsz + r - 1) / r;
  endfunction

  localparam int SZ_DEF       = 64;
  localparam int LOGSZ_DEF    = 7;
  localparam int RADIXLOG_DEF = 2;
  localparam int NSTAGES      = nstages(LOGSZ_DEF, RADIXLOG_DEF);
  localparam int CNTW         = $clog2(NSTAGES + 1);

endpackage

// File: rtl/align_shift_seq_if.sv
// Operand/result handshake bundle for align_shift_seq.
// slave = the shifter, master = the producer/consumer driving it.
interface align_shift_seq_if #(
  parameter int SZ    = 64,
  parameter int LOGSZ = 7
);
  logic             Flush;
  logic             InValid;
  logic             InReady;
  logic [SZ-1:0]    ShiftIn;
  logic [LOGSZ-1:0] ShiftAmt;
  logic             OutValid;
  logic             OutReady;
  logic [SZ-1:0]    Shifted;
  logic             Sticky;

  modport slave (
    input  Flush, InValid, ShiftIn,
    input  ShiftAmt, OutReady,
    output InReady, OutValid,
    output Shifted, Sticky
  );

  modport master (
    output Flush, InValid, ShiftIn,
    output ShiftAmt, OutReady,
    input  InReady, OutValid,
    input  Shifted, Sticky
  );
endinterface

// File: rtl/align_shift_stage.sv
// One radix chunk of the right shift: acc >> (chunk << idx*R)
// plus the OR of every bit pushed out past bit 0.
module align_shift_stage
  import align_shift_pkg::*;
#(
  parameter int SZ       = 64,
  parameter int RADIXLOG = 2,
  parameter int PADW     = 8,
  parameter int CW       = 3
) (
  input  logic [SZ-1:0]       acc_i,
  input  logic [RADIXLOG-1:0] chunk_i,
  input  logic [CW-1:0]       idx_i,
  output logic [SZ-1:0]       acc_o,
  output logic                drop_o
);

  logic [PADW-1:0] sh;

  // Shifts of SZ or more give zero and an all-ones drop mask.
  always_comb begin
    sh     = PADW'(chunk_i) << (32'(idx_i) * RADIXLOG);
    acc_o  = acc_i >> sh;
    drop_o = |(acc_i & ~({SZ{1'b1}} << sh));
  end

endmodule

// File: rtl/align_shift_seq.sv
// Multi-cycle right shifter with sticky, RADIXLOG amount bits per cycle.
// Define ALIGNSHIFT_EARLYOUT_EN to skip all-zero upper chunks and over-shifts.
module align_shift_seq
  import align_shift_pkg::*;
#(
  parameter int SZ       = 64,
  parameter int LOGSZ    = 7,
  parameter int RADIXLOG = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  align_shift_seq_if.slave  io
);

  localparam int NST  = nstages(LOGSZ, RADIXLOG);
  localparam int CW   = $clog2(NST + 1);
  localparam int PADW = NST * RADIXLOG;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [SZ-1:0]   acc_q;
  logic [SZ-1:0]   acc_d;
  logic [PADW-1:0] amt_q;
  logic            sticky_q;
  logic            drop_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            last_chunk;

  align_shift_stage #(
    .SZ       (SZ),
    .RADIXLOG (RADIXLOG),
    .PADW     (PADW),
    .CW       (CW)
  ) u_stage (
    .acc_i   (acc_q),
    .chunk_i (amt_q[RADIXLOG-1:0]),
    .idx_i   (cnt_q),
    .acc_o   (acc_d),
    .drop_o  (drop_d)
  );

  // amt_q is consumed LSB-first, so its low bits are always the live chunk.
  always_comb begin
    last_chunk = (cnt_q == CW'(NST - 1));
`ifdef ALIGNSHIFT_EARLYOUT_EN
    last_chunk = last_chunk
               || ((amt_q >> RADIXLOG) == '0);
`endif
  end

`ifdef ALIGNSHIFT_EARLYOUT_EN
  logic ovf;
  assign ovf = (io.ShiftAmt >= LOGSZ'(SZ));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      amt_q       <= '0;
      sticky_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (io.Flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.InValid) begin
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= io.ShiftIn;
            amt_q      <= PADW'(io.ShiftAmt);
            sticky_q   <= 1'b0;
`ifdef ALIGNSHIFT_EARLYOUT_EN
            // Resolve over-shift up front; a zero amount then finishes in one pass.
            if (ovf) begin
              acc_q    <= '0;
              amt_q    <= '0;
              sticky_q <= |io.ShiftIn;
            end
`endif
          end
        end
        SHIFT: begin
          acc_q    <= acc_d;
          sticky_q <= sticky_q | drop_d;
          amt_q    <= amt_q >> RADIXLOG;
          cnt_q    <= cnt_q + 1'b1;
          if (last_chunk) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (io.OutReady) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.InReady  = in_ready_q;
  assign io.OutValid = out_valid_q;
  assign io.Shifted  = acc_q;
  assign io.Sticky   = sticky_q;

endmodule

// File: tb/tb_align_shift_seq.sv
// Directed plus random bench for align_shift_seq against a wide-shift model.
// Latency expectations follow ALIGNSHIFT_EARLYOUT_EN when it is defined.
module tb_align_shift_seq;
  import align_shift_pkg::*;

  localparam int SZ    = 64;
  localparam int LOGSZ = 7;
  localparam int R     = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  align_shift_seq_if #(.SZ(SZ), .LOGSZ(LOGSZ)) bus ();

  align_shift_seq #(
    .SZ       (SZ),
    .LOGSZ    (LOGSZ),
    .RADIXLOG (R)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Result sits in the top word, everything shifted out lands below it.
  task automatic ref_model(input  logic [63:0] in,
                           input  int          amt,
                           output logic [63:0] sh,
                           output logic        st);
    logic [191:0] w;
    w  = {in, 128'd0} >> amt;
    sh = w[191:128];
    st = |w[127:0];
  endtask

  function automatic int ref_lat(input int amt);
    int l;
    l = NSTAGES;
`ifdef ALIGNSHIFT_EARLYOUT_EN
    l = 1;
    for (int k = 0; k < NSTAGES; k++)
      if ((amt >> (k * R)) != 0) l = k + 1;
    if (amt >= SZ) l = 1;
`endif
    return l;
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [63:0] in,
                        input int          amt,
                        input int          hold);
    logic [63:0] esh;
    logic        est;
    int          n;
    ref_model(in, amt, esh, est);
    check("in_ready_idle", 64'(bus.InReady), 64'd1);
    bus.InValid  = 1'b1;
    bus.ShiftIn  = in;
    bus.ShiftAmt = 7'(amt);
    bus.OutReady = 1'b0;
    edge1();
    bus.InValid  = 1'b0;
    bus.ShiftIn  = ~in;
    bus.ShiftAmt = ~bus.ShiftAmt;
    check("in_ready_busy", 64'(bus.InReady), 64'd0);
    n = 0;
    while (!bus.OutValid && n < 20) begin
      edge1();
      n++;
    end
    check("latency", 64'(n), 64'(ref_lat(amt)));
    check("shifted", bus.Shifted, esh);
    check("sticky", 64'(bus.Sticky), 64'(est));
    // A pending operand during backpressure must not be taken.
    bus.InValid = 1'b1;
    repeat (hold) begin
      edge1();
      check("hold_valid", 64'(bus.OutValid), 64'd1);
      check("hold_shifted", bus.Shifted, esh);
      check("hold_sticky", 64'(bus.Sticky), 64'(est));
      check("hold_in_ready", 64'(bus.InReady), 64'd0);
    end
    bus.OutReady = 1'b1;
    edge1();
    bus.OutReady = 1'b0;
    bus.InValid  = 1'b0;
    check("out_valid_clr", 64'(bus.OutValid), 64'd0);
    check("in_ready_back", 64'(bus.InReady), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(bus.InReady), 64'd1);
    check({tag, "_out_valid"}, 64'(bus.OutValid), 64'd0);
    check({tag, "_shifted"}, bus.Shifted, 64'd0);
    check({tag, "_sticky"}, 64'(bus.Sticky), 64'd0);
  endtask

  initial begin
    logic [63:0] rin;
    int          ramt;
    bus.Flush    = 1'b0;
    bus.InValid  = 1'b0;
    bus.ShiftIn  = '0;
    bus.ShiftAmt = '0;
    bus.OutReady = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;
    edge1();

    run_op(64'h8000_0000_0000_0001, 1, 0);
    run_op(64'hF, 0, 0);
    run_op(64'h1, 64, 0);
    run_op(64'h0, 127, 0);
    run_op(64'hDEAD_BEEF_0123_4567, 3, 0);
    run_op(64'hDEAD_BEEF_0123_4567, 100, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 63, 0);
    run_op(64'h0123_4567_89AB_CDEF, 37, 3);

    // Flush two chunks in, with a competing InValid.
    bus.InValid  = 1'b1;
    bus.ShiftIn  = 64'hA5A5_5A5A_F0F0_0F0F;
    bus.ShiftAmt = 7'd42;
    edge1();
    bus.InValid = 1'b0;
    edge1();
    edge1();
    bus.Flush   = 1'b1;
    bus.InValid = 1'b1;
    edge1();
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    check("flush_out_valid", 64'(bus.OutValid), 64'd0);
    check("flush_in_ready", 64'(bus.InReady), 64'd1);
    repeat (6) begin
      edge1();
      check("flush_quiet", 64'(bus.OutValid), 64'd0);
    end
    run_op(64'hA5A5_5A5A_F0F0_0F0F, 42, 1);

    // Asynchronous reset in the middle of a shift.
    bus.InValid  = 1'b1;
    bus.ShiftIn  = 64'hFFFF_0000_FFFF_0000;
    bus.ShiftAmt = 7'd42;
    edge1();
    bus.InValid = 1'b0;
    edge1();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    edge1();
    check_reset_vals("postreset");

    for (int i = 0; i < 150; i++) begin
      rin = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rin = '0;
      if ($urandom_range(0, 3) == 0)
        ramt = int'($urandom_range(64, 127));
      else
        ramt = int'($urandom_range(0, 63));
      run_op(rin, ramt, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
